// File: rtl/cpu2_pkg.sv
// ============================================================================
// cpu2_pkg : shared state encoding, extension modes and lane width for byte_lsu
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu2_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] EX_NEX = 2'b00;
  localparam logic [1:0] EX_ZEX = 2'b10;
  localparam logic [1:0] EX_SEX = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LRES  = 3'd2,
    ST_WR    = 3'd3,
    ST_SDONE = 3'd4
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_merge.sv
// ============================================================================
// byte_merge : replaces one byte lane of a word, leaving the other lanes intact
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_merge
  import cpu2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  word,
  input  logic [1:0]        idx,
  input  logic [BYTE_W-1:0] data,
  output logic [WIDTH-1:0]  merged
);

  always_comb begin
    merged = word;
    merged[idx*BYTE_W +: BYTE_W] = data;
  end

endmodule

`default_nettype wire

// File: rtl/byte_lsu.sv
// ============================================================================
// byte_lsu : single-outstanding byte load / read-modify-write store sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lsu
  import cpu2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [7:0]        req_wdata,
  input  logic [1:0]        req_ex_mode,
  input  logic [WIDTH-1:0]  req_opd,
  output logic              mem_cs,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_wait,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_opb,
  output logic [1:0]        res_idx,
  output logic [1:0]        res_ex_mode,
  output logic [WIDTH-1:0]  res_opd,
  output logic              st_done
);

  lsu_state_t        r_state;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic [WIDTH-1:0]  w_merged;

  // Merge against the word arriving this cycle; it is the same word latched into res_opb.
  byte_merge #(
    .WIDTH (WIDTH)
  ) u_merge (
    .word   (mem_rdata),
    .idx    (res_idx),
    .data   (r_wdata),
    .merged (w_merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      req_ready   <= 1'b1;
      mem_cs      <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      res_valid   <= 1'b0;
      res_opb     <= '0;
      res_idx     <= '0;
      res_ex_mode <= '0;
      res_opd     <= '0;
      st_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_we        <= req_we;
            r_wdata     <= req_wdata;
            res_idx     <= req_addr[1:0];
            res_ex_mode <= req_ex_mode;
            res_opd     <= req_opd;
            mem_addr    <= {2'b00, req_addr[AW-1:2]};
            mem_cs      <= 1'b1;
            mem_wen     <= 1'b0;
            req_ready   <= 1'b0;
            r_state     <= ST_RD;
          end
        end
        ST_RD: begin
          if (!mem_wait) begin
            res_opb <= mem_rdata;
            if (r_we) begin
              mem_wdata <= w_merged;
              mem_wen   <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              mem_cs    <= 1'b0;
              res_valid <= 1'b1;
              r_state   <= ST_LRES;
            end
          end
        end
        ST_LRES: begin
          res_valid <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_WR: begin
          if (!mem_wait) begin
            mem_cs  <= 1'b0;
            mem_wen <= 1'b0;
            st_done <= 1'b1;
            r_state <= ST_SDONE;
          end
        end
        ST_SDONE: begin
          st_done   <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          mem_cs    <= 1'b0;
          mem_wen   <= 1'b0;
          res_valid <= 1'b0;
          st_done   <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_byte_lsu.sv
// ============================================================================
// tb_byte_lsu : directed vector bench for byte_lsu
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_lsu;
  import cpu2_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [1:0]  req_ex_mode = '0;
  logic [31:0] req_opd = '0;
  logic        mem_cs;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_wait = 1'b0;
  logic        res_valid;
  logic [31:0] res_opb;
  logic [1:0]  res_idx;
  logic [1:0]  res_ex_mode;
  logic [31:0] res_opd;
  logic        st_done;

  int n_pass = 0;
  int n_total = 0;

  byte_lsu #(.WIDTH(32), .AW(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ex_mode (req_ex_mode),
    .req_opd     (req_opd),
    .mem_cs      (mem_cs),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_wait    (mem_wait),
    .res_valid   (res_valid),
    .res_opb     (res_opb),
    .res_idx     (res_idx),
    .res_ex_mode (res_ex_mode),
    .res_opd     (res_opd),
    .st_done     (st_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  ex;
    logic [31:0] opd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_maddr;
    logic [1:0]  exp_idx;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One full transaction; every check happens on a falling edge.
  task automatic run(input vec_t v);
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_ex_mode = v.ex; req_opd = v.opd; mem_wait = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= v.waits; k++) begin
      chk("rd_cs", {31'd0, mem_cs}, 32'd1);
      chk("rd_addr", mem_addr, v.exp_maddr);
      chk("rd_noready", {31'd0, req_ready}, 32'd0);
      mem_wait = 1'b1;
      @(negedge clk);
    end
    chk("rd_cs", {31'd0, mem_cs}, 32'd1);
    chk("rd_wen", {31'd0, mem_wen}, 32'd0);
    chk("rd_addr", mem_addr, v.exp_maddr);
    chk("rd_nores", {31'd0, res_valid}, 32'd0);
    mem_wait = 1'b0;
    mem_rdata = v.rdata;
    @(negedge clk);
    mem_rdata = 32'hDEADBEEF;
    if (v.we) begin
      chk("wr_cs", {31'd0, mem_cs}, 32'd1);
      chk("wr_wen", {31'd0, mem_wen}, 32'd1);
      chk("wr_addr", mem_addr, v.exp_maddr);
      chk("wr_wdata", mem_wdata, v.exp_wdata);
      chk("wr_nodone", {31'd0, st_done}, 32'd0);
      @(negedge clk);
      chk("st_done", {31'd0, st_done}, 32'd1);
      chk("sdone_cs", {31'd0, mem_cs}, 32'd0);
      @(negedge clk);
      chk("st_done_once", {31'd0, st_done}, 32'd0);
    end else begin
      chk("res_valid", {31'd0, res_valid}, 32'd1);
      chk("res_opb", res_opb, v.rdata);
      chk("res_idx", {30'd0, res_idx}, {30'd0, v.exp_idx});
      chk("res_ex", {30'd0, res_ex_mode}, {30'd0, v.ex});
      chk("res_opd", res_opd, v.opd);
      chk("lres_cs", {31'd0, mem_cs}, 32'd0);
      @(negedge clk);
      chk("res_valid_once", {31'd0, res_valid}, 32'd0);
      chk("res_opb_hold", res_opb, v.rdata);
    end
    chk("back_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0103, 8'h00, EX_ZEX, 32'h1234_5678, 32'hA1B2_C3D4, 0, 32'h0000_0040, 2'd3, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0ABC, 8'h00, EX_SEX, 32'h0BAD_F00D, 32'h8765_4321, 3, 32'h0000_02AF, 2'd0, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0012, 8'h5A, EX_NEX, 32'h0,         32'h1122_3344, 0, 32'h0000_0004, 2'd2, 32'h115A_3344};
    vecs[3] = '{1'b1, 32'h0000_0020, 8'hFF, EX_NEX, 32'h0,         32'h0000_0000, 0, 32'h0000_0008, 2'd0, 32'h0000_00FF};
    vecs[4] = '{1'b1, 32'h0000_0021, 8'hFF, EX_NEX, 32'h0,         32'h0000_0000, 0, 32'h0000_0008, 2'd1, 32'h0000_FF00};
    vecs[5] = '{1'b1, 32'h0000_0022, 8'hFF, EX_NEX, 32'h0,         32'h0000_0000, 0, 32'h0000_0008, 2'd2, 32'h00FF_0000};
    vecs[6] = '{1'b1, 32'h0000_0023, 8'hFF, EX_NEX, 32'h0,         32'h0000_0000, 0, 32'h0000_0008, 2'd3, 32'hFF00_0000};
    vecs[7] = '{1'b1, 32'hFFFF_FFFD, 8'h3C, EX_NEX, 32'h0,         32'hCAFE_BABE, 2, 32'h3FFF_FFFF, 2'd1, 32'hCAFE_3CBE};
    vecs[8] = '{1'b0, 32'h7FFF_FFFE, 8'h00, EX_NEX, 32'hFFFF_0000, 32'h0102_0304, 1, 32'h1FFF_FFFF, 2'd2, 32'h0};

    // Reset state
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_cs", {31'd0, mem_cs}, 32'd0);
    chk("rst_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_res", {29'd0, res_valid, st_done, |res_opb}, 32'd0);
    chk("rst_capt", {28'd0, res_idx, res_ex_mode} | res_opd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run(vecs[i]);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0205; req_ex_mode = EX_ZEX;
    req_opd = 32'h1111_1111; mem_wait = 1'b0; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    req_addr = 32'h0000_0302; req_ex_mode = EX_SEX; req_opd = 32'h2222_2222;
    chk("b2b_ready1", {31'd0, req_ready}, 32'd0);
    chk("b2b_addr1", mem_addr, 32'h0000_0081);
    @(negedge clk);
    chk("b2b_ready2", {31'd0, req_ready}, 32'd0);
    chk("b2b_res1", {31'd0, res_valid}, 32'd1);
    chk("b2b_idx1", {30'd0, res_idx}, 32'd1);
    chk("b2b_opd1", res_opd, 32'h1111_1111);
    @(negedge clk);
    chk("b2b_ready3", {31'd0, req_ready}, 32'd1);
    chk("b2b_nocs", {31'd0, mem_cs}, 32'd0);
    mem_rdata = 32'h3333_4444;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_cs2", {31'd0, mem_cs}, 32'd1);
    chk("b2b_addr2", mem_addr, 32'h0000_00C0);
    @(negedge clk);
    chk("b2b_res2", {31'd0, res_valid}, 32'd1);
    chk("b2b_opb2", res_opb, 32'h3333_4444);
    chk("b2b_idx2", {30'd0, res_idx}, 32'd2);
    chk("b2b_ex2", {30'd0, res_ex_mode}, {30'd0, EX_SEX});
    chk("b2b_opd2", res_opd, 32'h2222_2222);

    // Reset while a store write is stalled
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 8'h77;
    mem_wait = 1'b0; mem_rdata = 32'h0000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_wait = 1'b1;
    chk("rw_wr_cs", {31'd0, mem_cs}, 32'd1);
    chk("rw_wr_wen", {31'd0, mem_wen}, 32'd1);
    chk("rw_wr_data", mem_wdata, 32'h0000_0077);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_cs_drop", {31'd0, mem_cs}, 32'd0);
    chk("rw_wen_drop", {31'd0, mem_wen}, 32'd0);
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    mem_wait = 1'b0;
    @(negedge clk);
    chk("rw_no_done", {30'd0, st_done, mem_cs}, 32'd0);
    @(negedge clk);
    chk("rw_no_done2", {30'd0, st_done, mem_cs}, 32'd0);
    run(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/byte_lsu.md
Name: byte_lsu

Overview:
- Byte load/store sequencer for the cpu2 memory stage, directly upstream of the byte-extract/extend stage.
- Accepts one byte request at a time and reads the aligned 32-bit word from the wait-stated memory bus.
- Loads: registers the word, byte index, extension mode and destination operand, then presents them as one valid beat to the extract stage.
- Stores: performs a read-modify-write of the addressed byte lane.

Parameters:
- WIDTH, 32, data word width; must be 32 (four byte lanes).
- AW, 32, byte address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_we  in  1  1 = store byte, 0 = load byte
- req_addr  in  AW  byte address
- req_wdata  in  8  store byte
- req_ex_mode  in  2  load extension mode, forwarded unchanged (00 NEX, 10 ZEX, 11 SEX)
- req_opd  in  WIDTH  destination register old value, forwarded for NEX merge
- mem_cs  out  1  bus cycle active
- mem_wen  out  1  bus write strobe
- mem_addr  out  AW  word address = {2'b00, addr[AW-1:2]}
- mem_wdata  out  WIDTH  write data
- mem_rdata  in  WIDTH  read data, valid in the cycle mem_cs && !mem_wait
- mem_wait  in  1  bus stall; cycle completes when low
- res_valid  out  1  one-cycle load-result beat
- res_opb  out  WIDTH  fetched word
- res_idx  out  2  byte index = addr[1:0]
- res_ex_mode  out  2  captured extension mode
- res_opd  out  WIDTH  captured destination operand
- st_done  out  1  one-cycle store completion pulse

Behaviour:
- States: IDLE, RD, LRES, WR, SDONE.
- Reset (async, reset_n low) puts the FSM in IDLE.
  - Reset values: all outputs 0 except req_ready = 1.
  - All capture registers reset to 0.
- IDLE, on accept:
  - Capture we, addr, wdata, ex_mode, opd.
  - Go to RD.
- RD:
  - mem_cs = 1, mem_wen = 0, mem_addr = captured word address.
  - Stay while mem_wait = 1; outputs remain stable.
  - When mem_wait = 0, latch mem_rdata into the word register.
  - Next state: LRES if load, WR if store.
- LRES:
  - res_valid = 1 for exactly one cycle; res_* driven from capture registers.
  - Next state: IDLE.
- WR:
  - mem_cs = 1, mem_wen = 1.
  - mem_wdata = latched word with lane idx replaced by wdata (idx 0 → bits 7:0 … idx 3 → bits 31:24); other lanes bit-exact.
  - Stay while mem_wait = 1, data and address held.
  - When mem_wait = 0, go to SDONE.
- SDONE:
  - st_done = 1 for one cycle.
  - Next state: IDLE.
- Zero-wait latency from the accept edge:
  - Load: res_valid in cycle +2.
  - Store: write at +2, st_done at +3.
  - Each wait cycle adds one cycle.
- res_* hold their last captured values outside LRES; consumers qualify with res_valid.
- No pipelining: req_ready stays low from accept until return to IDLE; req_valid in other states is ignored (no capture).
- Misalignment cannot occur: every byte address is legal; addr[1:0] selects only the lane.
- Reset mid-operation (RD or WR): immediate return to IDLE, mem_cs drops asynchronously, no result or done pulse. A partial store write is acceptable and software-visible.
- mem_rdata is sampled only in RD when mem_wait = 0.

Decomposition:
- Shared package (cpu2_pkg):
  - State encoding constants.
  - Extension-mode constants EX_NEX = 2'b00, EX_ZEX = 2'b10, EX_SEX = 2'b11.
  - Byte-lane width constant 8.
- One natural sub-module: byte_merge (combinational lane replace of word, idx, byte), instantiated for WR data.

Test Plan:
- Load, zero wait: addr 0x103, mem_rdata 0xA1B2C3D4 → res_valid at +2, res_opb 0xA1B2C3D4, res_idx 3, mem_addr 0x40, ex_mode forwarded.
- Load, 3 wait cycles: mem_wait high for 3 cycles in RD → mem_addr/mem_cs stable; res_valid at +5 for exactly 1 cycle.
- Store: addr 0x12, wdata 0x5A, read word 0x11223344 → WR mem_wdata 0x115A3344, mem_wen = 1, st_done at +3.
- Back-to-back requests: req_valid held high with two requests → second accepted only after IDLE re-entered; req_ready low throughout the first.
- Reset in WR with mem_wait high → mem_cs = 0 immediately, state IDLE, no st_done; the next load completes normally.
- All four lane indices, store 0xFF into word 0x00000000 → 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000.
